// File: rtl/regfile_sequencer_if.sv
// Command handshake plus register-file control/read-data bundle between requester, sequencer and register file.
interface regfile_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic [7:0] cmd_imm;
  logic [3:0] cmd_cnt;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic [7:0] rf_i;
  logic [2:0] rf_o1sel;
  logic [2:0] rf_o2sel;
  logic [1:0] rf_funsel;
  logic [3:0] rf_rsel;
  logic [3:0] rf_tsel;
  logic [7:0] rf_o1;
  logic [7:0] rf_o2;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_cnt, rf_o1, rf_o2,
    input  cmd_ready, busy, done, rd_data, rf_i, rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_cnt, rf_o1, rf_o2,
    output cmd_ready, busy, done, rd_data, rf_i, rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Expands one register-transfer command into register file select/function/enable cycles (1 to 16 busy cycles).
// cmd_ready is high only in IDLE; a command offered while busy stays pending until the sequencer returns to IDLE.
module regfile_sequencer (
  input  logic                clk,
  input  logic                rst,
  regfile_sequencer_if.slave  sif
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, WRITE, WRITE2, STEP, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    logic [7:0] imm;
  } cmd_t;

  state_t     state, state_nxt;
  cmd_t       cmd_q;
  logic [3:0] cnt_q;
  logic [7:0] hold_a, hold_b, rd_q;
  logic [2:0] o1sel_q, o2sel_q;
  logic       accept;
  logic       wr_en;
  logic [2:0] wr_code;
  logic [3:0] wr_onehot;
  logic [1:0] funsel;
  logic [7:0] wr_dat;

  assign accept        = sif.cmd_valid && (state == IDLE);
  assign sif.cmd_ready = (state == IDLE);
  assign sif.busy      = (state != IDLE);
  assign sif.done      = (state == DONE);
  assign sif.rd_data   = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
      rd_q    <= '0;
      o1sel_q <= '0;
      o2sel_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q <= '{op: sif.cmd_op, dst: sif.cmd_dst, src: sif.cmd_src, imm: sif.cmd_imm};
        cnt_q <= sif.cmd_cnt;
      end
      if (state == STEP) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Selects are latched so the read ports keep pointing at the last operands
      if (state == READ) begin
        o1sel_q <= cmd_q.src;
        hold_a  <= sif.rf_o1;
        if (cmd_q.op == OP_SWAP) begin
          o2sel_q <= cmd_q.dst;
          hold_b  <= sif.rf_o2;
        end
        if (cmd_q.op == OP_RD) begin
          rd_q <= sif.rf_o1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_code   = cmd_q.dst;
    funsel    = 2'b00;
    wr_dat    = 8'h00;
    case (state)
      IDLE: begin
        if (accept) begin
          case (sif.cmd_op)
            OP_NOP:         state_nxt = DONE;
            OP_CLR, OP_LDI: state_nxt = WRITE;
            OP_INC, OP_DEC: state_nxt = (sif.cmd_cnt == 4'd0) ? DONE : STEP;
            OP_MOV, OP_SWAP,
            OP_RD:          state_nxt = READ;
          endcase
        end
      end
      READ: begin
        state_nxt = (cmd_q.op == OP_RD) ? DONE : WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        funsel    = (cmd_q.op == OP_CLR) ? 2'b00 : 2'b01;
        if (cmd_q.op == OP_LDI) begin
          wr_dat = cmd_q.imm;
        end else if (cmd_q.op == OP_MOV || cmd_q.op == OP_SWAP) begin
          wr_dat = hold_a;
        end
        state_nxt = (cmd_q.op == OP_SWAP) ? WRITE2 : DONE;
      end
      WRITE2: begin
        wr_en     = 1'b1;
        wr_code   = cmd_q.src;
        funsel    = 2'b01;
        wr_dat    = hold_b;
        state_nxt = DONE;
      end
      STEP: begin
        wr_en     = 1'b1;
        funsel    = (cmd_q.op == OP_INC) ? 2'b11 : 2'b10;
        state_nxt = (cnt_q == 4'd1) ? DONE : STEP;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Code bit 2 picks the R bank; the low bits pick R1/T1 (bit3) down to R4/T4 (bit0)
  assign wr_onehot     = 4'b1000 >> wr_code[1:0];
  assign sif.rf_rsel   = (wr_en && !rst && wr_code[2])  ? wr_onehot : 4'b0000;
  assign sif.rf_tsel   = (wr_en && !rst && !wr_code[2]) ? wr_onehot : 4'b0000;
  assign sif.rf_funsel = funsel;
  assign sif.rf_i      = wr_dat;
  assign sif.rf_o1sel  = (state == READ) ? cmd_q.src : o1sel_q;
  assign sif.rf_o2sel  = (state == READ && cmd_q.op == OP_SWAP) ? cmd_q.dst : o2sel_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: register file environment model, command-level expectation queue, and literal spot checks.
module tb_regfile_sequencer;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef struct {
    logic       busy;
    logic       done;
    logic       ready;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [1:0] fun;
    logic [7:0] i;
    logic [7:0] rd;
    logic [2:0] o1;
    logic [2:0] o2;
  } exp_t;

  logic clk;
  logic rst;
  regfile_sequencer_if sif ();

  regfile_sequencer dut (.clk(clk), .rst(rst), .sif(sif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rf_mem [8];
  logic [7:0] refr   [8];
  exp_t       q [$];
  logic [2:0] tail_o1, tail_o2;
  logic [7:0] tail_rd;
  logic       armed;
  int         n_checks, n_pass;
  logic [3:0] first_rsel, first_tsel;
  logic [1:0] first_fun;
  logic [7:0] first_i;

  assign sif.rf_o1 = rf_mem[sif.rf_o1sel];
  assign sif.rf_o2 = rf_mem[sif.rf_o2sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Register file environment: writes land on the rising edge
  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      logic       en;
      cc = 3'(c);
      en = cc[2] ? sif.rf_rsel[3 - cc[1:0]] : sif.rf_tsel[3 - cc[1:0]];
      if (en) begin
        case (sif.rf_funsel)
          2'b00: rf_mem[c] <= 8'h00;
          2'b01: rf_mem[c] <= sif.rf_i;
          2'b10: rf_mem[c] <= rf_mem[c] - 8'd1;
          2'b11: rf_mem[c] <= rf_mem[c] + 8'd1;
        endcase
      end
    end
  end

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
    e.rsel = '0; e.tsel = '0; e.fun = '0; e.i = '0;
    e.rd = tail_rd; e.o1 = tail_o1; e.o2 = tail_o2;
    return e;
  endfunction

  function automatic exp_t with_en(input exp_t x, input logic [2:0] code, input logic [1:0] fun, input logic [7:0] i);
    exp_t y;
    y = x;
    y.fun = fun;
    y.i = i;
    if (code[2]) y.rsel[3 - code[1:0]] = 1'b1;
    else         y.tsel[3 - code[1:0]] = 1'b1;
    return y;
  endfunction

  // Expand an accepted command into the cycles that must follow and apply its effect to the reference registers
  task automatic gen(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                     input logic [7:0] imm, input logic [3:0] cnt);
    exp_t b;
    logic [7:0] vs, vd;
    vs = refr[src];
    vd = refr[dst];
    b = idle_exp();
    b.ready = 1'b0;
    b.busy = 1'b1;
    case (op)
      OP_CLR: begin q.push_back(with_en(b, dst, 2'b00, 8'h00)); refr[dst] = 8'h00; end
      OP_LDI: begin q.push_back(with_en(b, dst, 2'b01, imm)); refr[dst] = imm; end
      OP_INC: begin
        for (int n = 0; n < int'(cnt); n++) q.push_back(with_en(b, dst, 2'b11, 8'h00));
        refr[dst] = vd + {4'b0, cnt};
      end
      OP_DEC: begin
        for (int n = 0; n < int'(cnt); n++) q.push_back(with_en(b, dst, 2'b10, 8'h00));
        refr[dst] = vd - {4'b0, cnt};
      end
      OP_MOV: begin
        tail_o1 = src; b.o1 = src;
        q.push_back(b);
        q.push_back(with_en(b, dst, 2'b01, vs));
        refr[dst] = vs;
      end
      OP_SWAP: begin
        tail_o1 = src; tail_o2 = dst; b.o1 = src; b.o2 = dst;
        q.push_back(b);
        q.push_back(with_en(b, dst, 2'b01, vs));
        q.push_back(with_en(b, src, 2'b01, vd));
        refr[dst] = vs;
        refr[src] = vd;
      end
      OP_RD: begin
        tail_o1 = src; b.o1 = src;
        q.push_back(b);
        tail_rd = vs; b.rd = vs;
      end
      default: ;
    endcase
    b.done = 1'b1;
    q.push_back(b);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic idle_now;
    idle_now = (q.size() == 0);
    if (idle_now) e = idle_exp();
    else          e = q.pop_front();
    if (armed) begin
      check("cyc_ready", sif.cmd_ready, e.ready);
      check("cyc_busy", sif.busy, e.busy);
      check("cyc_done", sif.done, e.done);
      check("cyc_rsel", sif.rf_rsel, rst ? 4'b0 : e.rsel);
      check("cyc_tsel", sif.rf_tsel, rst ? 4'b0 : e.tsel);
      check("cyc_funsel", sif.rf_funsel, e.fun);
      check("cyc_rf_i", sif.rf_i, e.i);
      check("cyc_rd_data", sif.rd_data, e.rd);
      check("cyc_o1sel", sif.rf_o1sel, e.o1);
      check("cyc_o2sel", sif.rf_o2sel, e.o2);
    end
    if (rst) begin
      q.delete();
      tail_o1 = '0; tail_o2 = '0; tail_rd = '0;
    end else if (idle_now && sif.cmd_valid) begin
      gen(sif.cmd_op, sif.cmd_dst, sif.cmd_src, sif.cmd_imm, sif.cmd_cnt);
    end
  end

  // Returns k = index of the done cycle counted from the accept edge
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] imm, input logic [3:0] cnt, output int k);
    int w;
    sif.cmd_op = op; sif.cmd_dst = dst; sif.cmd_src = src;
    sif.cmd_imm = imm; sif.cmd_cnt = cnt; sif.cmd_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!sif.cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!sif.cmd_ready) check("accept_timeout", sif.cmd_ready, 1);
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
    @(negedge clk);
    k = 1;
    first_rsel = sif.rf_rsel; first_tsel = sif.rf_tsel;
    first_fun = sif.rf_funsel; first_i = sif.rf_i;
    while (!sif.done && k < 50) begin @(negedge clk); k++; end
    if (!sif.done) check("done_timeout", sif.done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k;
    n_checks = 0; n_pass = 0; armed = 1'b0;
    tail_o1 = '0; tail_o2 = '0; tail_rd = '0;
    for (int c = 0; c < 8; c++) begin rf_mem[c] = 8'h00; refr[c] = 8'h00; end
    rst = 1'b1;
    sif.cmd_valid = 1'b0; sif.cmd_op = '0; sif.cmd_dst = '0;
    sif.cmd_src = '0; sif.cmd_imm = '0; sif.cmd_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    check("rst_ready", sif.cmd_ready, 1);
    check("rst_busy", sif.busy, 0);
    check("rst_rd_data", sif.rd_data, 0);
    @(posedge clk); #1;

    issue(OP_LDI, 3'b100, 3'b000, 8'h5E, 4'd0, k);
    check("ldi_latency", k, 2);
    check("ldi_rsel", first_rsel, 4'b1000);
    check("ldi_funsel", first_fun, 2'b01);
    check("ldi_rf_i", first_i, 8'h5E);
    issue(OP_RD, 3'b000, 3'b100, 8'h00, 4'd0, k);
    check("rd_latency", k, 2);
    check("rd_r1", sif.rd_data, 8'h5E);

    issue(OP_LDI, 3'b001, 3'b000, 8'hFE, 4'd0, k);
    issue(OP_INC, 3'b001, 3'b000, 8'h00, 4'd3, k);
    check("inc_latency", k, 4);
    check("inc_tsel", first_tsel, 4'b0100);
    check("inc_funsel", first_fun, 2'b11);
    issue(OP_RD, 3'b000, 3'b001, 8'h00, 4'd0, k);
    check("rd_t2_wrap", sif.rd_data, 8'h01);
    issue(OP_INC, 3'b001, 3'b000, 8'h00, 4'd0, k);
    check("inc0_latency", k, 1);
    check("inc0_tsel", first_tsel, 4'b0000);
    check("inc0_rsel", first_rsel, 4'b0000);

    issue(OP_LDI, 3'b101, 3'b000, 8'h18, 4'd0, k);
    issue(OP_LDI, 3'b011, 3'b000, 8'hA5, 4'd0, k);
    issue(OP_SWAP, 3'b101, 3'b011, 8'h00, 4'd0, k);
    check("swap_latency", k, 4);
    issue(OP_RD, 3'b000, 3'b101, 8'h00, 4'd0, k);
    check("swap_r2", sif.rd_data, 8'hA5);
    issue(OP_RD, 3'b000, 3'b011, 8'h00, 4'd0, k);
    check("swap_t4", sif.rd_data, 8'h18);
    issue(OP_SWAP, 3'b101, 3'b101, 8'h00, 4'd0, k);
    issue(OP_RD, 3'b000, 3'b101, 8'h00, 4'd0, k);
    check("swap_self_r2", sif.rd_data, 8'hA5);

    // MOV R4 <- R1 with a follow-up RD held on the bus while busy
    sif.cmd_op = OP_MOV; sif.cmd_dst = 3'b111; sif.cmd_src = 3'b100; sif.cmd_valid = 1'b1;
    @(negedge clk);
    check("mov_accept_ready", sif.cmd_ready, 1);
    @(posedge clk); #1;
    sif.cmd_op = OP_RD; sif.cmd_src = 3'b111;
    k = 0;
    do begin @(negedge clk); k++; end while (!sif.cmd_ready && k < 20);
    check("mov_pending_span", k, 4);
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!sif.done && k < 20);
    check("held_rd_latency", k, 2);
    @(posedge clk); #1;
    check("mov_r4", sif.rd_data, 8'h5E);
    issue(OP_RD, 3'b000, 3'b100, 8'h00, 4'd0, k);
    check("mov_r1_kept", sif.rd_data, 8'h5E);

    // DEC R3 cnt 15, reset during the 5th STEP cycle
    issue(OP_LDI, 3'b110, 3'b000, 8'h40, 4'd0, k);
    sif.cmd_op = OP_DEC; sif.cmd_dst = 3'b110; sif.cmd_cnt = 4'd15; sif.cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_gate_rsel", sif.rf_rsel, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", sif.cmd_ready, 1);
    check("abort_done", sif.done, 0);
    check("abort_funsel", sif.rf_funsel, 2'b00);
    check("abort_o1sel", sif.rf_o1sel, 3'b000);
    check("abort_r3", rf_mem[6], 8'h3C);
    refr[6] = 8'h3C;
    @(posedge clk); #1;
    issue(OP_RD, 3'b000, 3'b110, 8'h00, 4'd0, k);
    check("abort_rd_r3", sif.rd_data, 8'h3C);

    issue(OP_LDI, 3'b000, 3'b000, 8'hFF, 4'd0, k);
    issue(OP_CLR, 3'b000, 3'b000, 8'h00, 4'd0, k);
    check("clr_funsel", first_fun, 2'b00);
    check("clr_tsel", first_tsel, 4'b1000);
    issue(OP_RD, 3'b000, 3'b000, 8'h00, 4'd0, k);
    check("clr_t1", sif.rd_data, 8'h00);
    issue(OP_NOP, 3'b000, 3'b000, 8'h00, 4'd0, k);
    check("nop_latency", k, 1);

    for (int c = 0; c < 8; c++) check($sformatf("final_reg%0d", c), rf_mem[c], refr[c]);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
